// File: rtl/prefix_add_seq.sv
// prefix_add_seq: multicycle Kogge-Stone adder for the FP mantissa path.
// One prefix stage is reused over NSTAGES iterations, with the combine
// distance doubling on each pass (1, 2, 4, 8, 16). Operands enter and the
// result leaves through valid/ready handshakes.
// Optional build macro: PREFIX_SKIP_EN. When it is defined, the prefix phase
// ends early once every propagate bit is zero, because any remaining
// combines could not change the generate vector.
module prefix_add_seq #(
  parameter int WIDTH   = 17,
  parameter int NSTAGES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam logic [CW-1:0] LAST_STAGE = CW'(NSTAGES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] g_r, g_s;
  logic [WIDTH-1:0] p_r, p_s;
  logic [WIDTH-1:0] p0_r, p0_s;
  logic             cin_r, cin_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             cout_r, cout_s;
  logic             last_s;
  int unsigned      shamt_s;

  // Vector-wide prefix combine: the hi operand is each pair, and the lo
  // operand is the pair d positions below it (pre-shifted by the caller).
  function automatic logic [2*WIDTH-1:0] combine(
    input logic [WIDTH-1:0] g_hi,
    input logic [WIDTH-1:0] p_hi,
    input logic [WIDTH-1:0] g_lo,
    input logic [WIDTH-1:0] p_lo
  );
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  // Next-state, datapath update and next values for the registered outputs.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    g_s         = g_r;
    p_s         = p_r;
    p0_s        = p0_r;
    cin_s       = cin_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    sum_s       = sum_r;
    cout_s      = cout_r;
    shamt_s     = 32'd1 << cnt_r;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          p0_s       = a ^ b;
          p_s        = a ^ b;
          g_s        = a & b;
          // The carry-in is folded into the bit-0 generate term.
          g_s[0]     = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
          cin_s      = cin;
          cnt_s      = {CW{1'b0}};
          in_ready_s = 1'b0;
          state_s    = PREFIX;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      PREFIX: begin
        // Shifting in zeros leaves g unchanged for i<d. Filling p_lo with
        // ones keeps p unchanged there too, so low pairs never wrap around.
        {g_s, p_s} = combine(g_r, p_r, g_r << shamt_s,
                             (p_r << shamt_s) | ~({WIDTH{1'b1}} << shamt_s));
`ifdef PREFIX_SKIP_EN
        last_s = (cnt_r == LAST_STAGE) || (p_r == {WIDTH{1'b0}});
`else
        last_s = (cnt_r == LAST_STAGE);
`endif
        if (last_s) begin
          state_s     = DONE;
          cnt_s       = {CW{1'b0}};
          out_valid_s = 1'b1;
          sum_s       = p0_r ^ {g_s[WIDTH-2:0], cin_r};
          cout_s      = g_s[WIDTH-1];
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        cnt_s       = {CW{1'b0}};
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State, pair registers and the registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      g_r         <= {WIDTH{1'b0}};
      p_r         <= {WIDTH{1'b0}};
      p0_r        <= {WIDTH{1'b0}};
      cin_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      g_r         <= g_s;
      p_r         <= p_s;
      p0_r        <= p0_s;
      cin_r       <= cin_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      sum_r       <= sum_s;
      cout_r      <= cout_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_prefix_add_seq.sv
// Directed and random self-checking bench for prefix_add_seq.
module tb_prefix_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] a = 17'd0;
  logic [16:0] b = 17'd0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] sum;
  logic        cout;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic [16:0] hold_sum;
  logic        hold_cout;

  prefix_add_seq #(.WIDTH(17), .NSTAGES(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set at posedge+1, then count edges until out_valid.
  task automatic start_op(input logic [16:0] va, input logic [16:0] vb, input logic vc, output int l);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; a = va; b = vb; cin = vc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 17'($urandom); b = 17'($urandom); cin = 1'($urandom);
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1; l++;
    end
    if (l >= 20) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full carry ripple out of the top bit
    start_op(17'h1FFFF, 17'h00001, 1'b0, lat);
    chk("t1_sum", 32'(sum), 32'h00000);
    chk("t1_cout", 32'(cout), 32'd1);
    chk("t1_latency", 32'(lat), 32'd5);
    chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
    finish_op();
    chk("t1_out_valid_clr", 32'(out_valid), 32'd0);
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);
    chk("t1_sum_hold", 32'(sum), 32'h00000);

    // Carry-in propagates across the whole 16-bit chain
    start_op(17'h0AAAA, 17'h05555, 1'b1, lat);
    chk("t2_sum", 32'(sum), 32'h10000);
    chk("t2_cout", 32'(cout), 32'd0);
    chk("t2_latency", 32'(lat), 32'd5);

    // Backpressure: result held for 3 stalled cycles, in_valid ignored
    in_valid = 1'b1; a = 17'h00001; b = 17'h00001; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'h10000);
      chk("bp_cout", 32'(cout), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_accept_next", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_next_sum", 32'(sum), 32'h00002);
    finish_op();

    // Reset during the third PREFIX cycle aborts the operation
    in_valid = 1'b1; a = 17'h1FFFF; b = 17'h1FFFF; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(17'h00003, 17'h00005, 1'b0, lat);
    chk("post_rst_sum", 32'(sum), 32'h00008);
    chk("post_rst_cout", 32'(cout), 32'd0);
    chk("post_rst_latency", 32'(lat), 32'd5);
    finish_op();

    // No propagate bits at all: early exit when the skip feature is built in
    start_op(17'h12345, 17'h12345, 1'b0, lat);
    chk("dbl_sum", 32'(sum), 32'h0468A);
    chk("dbl_cout", 32'(cout), 32'd1);
`ifdef PREFIX_SKIP_EN
    chk("dbl_latency", 32'(lat), 32'd1);
`else
    chk("dbl_latency", 32'(lat), 32'd5);
`endif
    finish_op();

    // Random operands with random result stalls
    for (int n = 0; n < 1000; n++) begin
      logic [16:0] ra, rb;
      logic        rc;
      logic [17:0] expv;
      int          stall;
      ra = 17'($urandom); rb = 17'($urandom); rc = 1'($urandom);
      if (n % 7 == 0) rb = ~ra;
      expv = {1'b0, ra} + {1'b0, rb} + {17'd0, rc};
      start_op(ra, rb, rc, lat);
      chk("rnd_result", 32'({cout, sum}), 32'(expv));
`ifdef PREFIX_SKIP_EN
      chk("rnd_latency_le5", 32'(lat >= 1 && lat <= 5), 32'd1);
`else
      chk("rnd_latency", 32'(lat), 32'd5);
`endif
      hold_sum = sum; hold_cout = cout;
      stall = int'($urandom_range(0, 2));
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk("rnd_stall_hold", 32'({out_valid, cout, sum}), 32'({1'b1, expv}));
      end
      finish_op();
      chk("rnd_done_clear", 32'({out_valid, in_ready}), 32'b01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefix_add_seq.md
Name: prefix_add_seq

Overview:
- Multicycle parallel-prefix adder controller for the floating-point adder's mantissa path.
- Time-multiplexes one Kogge-Stone prefix stage over NSTAGES iterations instead of instantiating every stage. Iteration k uses combine distance 2^k (1, 2, 4, 8, 16).
- Sequences operand capture, prefix iterations and sum formation, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 17, operand/sum width in bits.
- NSTAGES, 5, prefix iterations; must equal ceil(log2(WIDTH)).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low forces:
  - state=IDLE, stage counter=0, all pair/propagate registers=0;
  - in_ready=1, out_valid=0, sum=0, cout=0.
- Pair state: WIDTH 2-bit (g,p) registers plus a WIDTH-bit saved propagate vector p0.
- Combine op, hi pair i with lo pair j: g = g_i | (p_i & g_j); p = p_i & p_j.
- FSM states: IDLE, PREFIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: p0[i]=a[i]^b[i]; g[i]=a[i]&b[i]; p[i]=p0[i].
  - Bit 0 absorbs carry-in: g[0]=(a[0]&b[0]) | ((a[0]^b[0]) & cin).
  - Counter=0; go to PREFIX.
- PREFIX:
  - in_ready=0.
  - Each edge: d=2^counter. For i>=d, pair[i] = combine(pair[i], pair[i-d]) using pre-edge values. Pairs i<d are unchanged.
  - Counter increments each edge. On the edge where counter==NSTAGES-1, go to DONE; counter returns to 0.
- DONE:
  - out_valid=1.
  - sum[0]=p0[0]^cin_saved; sum[i]=p0[i]^g[i-1] for i>=1; cout=g[WIDTH-1]. These outputs are registered on DONE entry.
  - cin_saved is the cin captured at acceptance.
  - On out_valid & out_ready: go to IDLE, out_valid=0; sum/cout hold their last values.
- Latency: out_valid asserted NSTAGES cycles after the accept edge. Throughput: one operation per NSTAGES+2 cycles minimum.
- Backpressure: while out_valid & !out_ready, sum/cout/out_valid stay stable and in_ready=0.
- in_valid is ignored outside IDLE. Operands are not re-sampled after acceptance, so a and b may change freely after the accept edge.
- Reset mid-operation (PREFIX or DONE) aborts immediately. No partial result is ever presented.
- WIDTH not a power of two: pairs with i-d<0 are never combined; no wrap-around.

Optional Feature:
- Macro: PREFIX_SKIP_EN.
- Defined: in PREFIX, if all WIDTH p bits of the pair state are 0 before an edge, that edge goes directly to DONE.
  - Remaining combines would be no-ops, so results are identical.
  - Check also applies in the first PREFIX cycle. Minimum latency is 1 cycle after accept.
- Undefined: latency is fixed at NSTAGES; no zero-detect logic is present.

Test Plan:
- a=0x1FFFF, b=0x00001, cin=0 -> sum=0x00000, cout=1; out_valid exactly 5 cycles after accept.
- a=0x0AAAA, b=0x05555, cin=1 -> sum=0x10000, cout=0; exercises the full 16-bit carry chain through every distance.
- Backpressure: complete an op, then hold out_ready=0 for 3 cycles -> sum/cout/out_valid stable, in_ready=0. A new in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-op: rst_n low during the third PREFIX cycle -> out_valid=0, in_ready=1 asynchronously. Next op a=0x00003, b=0x00005, cin=0 -> sum=0x00008, cout=0.
- PREFIX_SKIP_EN defined: a=b=0x12345, cin=0 -> sum=0x0468A, cout=1, out_valid 1 cycle after accept. Undefined: same result at 5 cycles.
- 1000 random (a, b, cin) with random out_ready stalls -> every result matches the reference model of a+b+cin.
